// File: rtl/conv_sched_pkg.sv
// conv_pkg: shared types and helpers for the convolution scheduler.
//   state_e      scheduler FSM states
//   OP_COUNT     output count for the default vector/filter sizes
//   group_lanes  number of live lanes in the group starting at output g
package conv_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, FLUSH, DRAIN} state_e;

  localparam int X_COUNT_DFLT = 64;
  localparam int F_COUNT_DFLT = 33;
  localparam int P_DFLT       = 8;
  localparam int OP_COUNT     = X_COUNT_DFLT - F_COUNT_DFLT + 1;

  // The final group may be short when the output count is not a multiple of P.
  function automatic int group_lanes(input int op_count, input int g, input int p);
    return (op_count - g < p) ? (op_count - g) : p;
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// conv_sched_if: control bus between the scheduler and the convolution datapath.
//   input side : s_valid_x / s_ready_x handshake, wr_en_x write strobe
//   addressing : addr_x_base (lane 0 x address), addr_f (filter tap)
//   MAC control: en_acc, clear_acc
//   output side: lane_sel, m_valid_y / m_ready_y handshake, m_last_y
// master = scheduler, slave = datapath / consumer side.
interface conv_sched_if #(
  parameter int ADDR_X = 6,
  parameter int ADDR_F = 6,
  parameter int LANE_W = 3
);
  logic              s_valid_x;
  logic              s_ready_x;
  logic              wr_en_x;
  logic [ADDR_X-1:0] addr_x_base;
  logic [ADDR_F-1:0] addr_f;
  logic              en_acc;
  logic              clear_acc;
  logic [LANE_W-1:0] lane_sel;
  logic              m_valid_y;
  logic              m_ready_y;
  logic              m_last_y;

  modport master (
    input  s_valid_x, m_ready_y,
    output s_ready_x, wr_en_x, addr_x_base, addr_f, en_acc, clear_acc,
           lane_sel, m_valid_y, m_last_y
  );

  modport slave (
    output s_valid_x, m_ready_y,
    input  s_ready_x, wr_en_x, addr_x_base, addr_f, en_acc, clear_acc,
           lane_sel, m_valid_y, m_last_y
  );
endinterface

// File: rtl/sched_delay_line.sv
// sched_delay_line: 1-bit valid shift register, DEPTH cycles of latency.
//   clk_i, rst_ni : clock, async active-low reset
//   d_i           : valid in
//   q_o           : valid delayed by DEPTH cycles
module sched_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH:0] vld_pipe;
  logic [DEPTH:1] pipe_q;

  assign vld_pipe = {pipe_q, d_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pipe_q <= '0;
    else         pipe_q <= vld_pipe[DEPTH-1:0];
  end

  assign q_o = vld_pipe[DEPTH];

endmodule

// File: rtl/conv_sched.sv
// conv_sched: control FSM for the P-lane 1-D convolution datapath.
// Loads X_COUNT samples, then for each group of up to P outputs issues
// F_COUNT tap addresses, waits out the read/multiply pipe, and drains the
// lanes one at a time on the output handshake. Owns no data.
//   clk, reset : clock, async active-low reset
//   bus        : conv_sched_if master (handshakes, addresses, MAC control)
module conv_sched
  import conv_pkg::*;
#(
  parameter int X_COUNT  = 64,
  parameter int F_COUNT  = 33,
  parameter int P        = 8,
  parameter int PIPE_LAT = 2,
  parameter int ADDR_X   = $clog2(X_COUNT),
  parameter int ADDR_F   = $clog2(F_COUNT),
  parameter int LANE_W   = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          reset,
  conv_sched_if.master  bus
);

  localparam int N_OUT = X_COUNT - F_COUNT + 1;
  localparam int FW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e            state_q, state_d;
  logic [ADDR_X-1:0] wcnt_q, wcnt_d;   // write count while loading
  logic [ADDR_X-1:0] g_q, g_d;         // first output index of current group
  logic [ADDR_F-1:0] k_q, k_d;         // filter tap
  logic [FW-1:0]     fcnt_q, fcnt_d;   // flush cycle count
  logic [LANE_W-1:0] lane_q, lane_d;   // lane being drained
  logic              issue;
  logic              en_acc;
  int                lanes;

  assign lanes = group_lanes(N_OUT, int'(g_q), P);

  // en_acc tracks issued taps once their product reaches the MAC input.
  sched_delay_line #(.DEPTH(PIPE_LAT)) u_dly (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (issue),
    .q_o    (en_acc)
  );

  assign bus.en_acc = en_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      wcnt_q  <= '0;
      g_q     <= '0;
      k_q     <= '0;
      fcnt_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      g_q     <= g_d;
      k_q     <= k_d;
      fcnt_q  <= fcnt_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    g_d             = g_q;
    k_d             = k_q;
    fcnt_d          = fcnt_q;
    lane_d          = lane_q;
    issue           = 1'b0;
    bus.s_ready_x   = 1'b0;
    bus.wr_en_x     = 1'b0;
    bus.addr_x_base = '0;
    bus.addr_f      = '0;
    bus.clear_acc   = 1'b0;
    bus.m_valid_y   = 1'b0;
    bus.lane_sel    = lane_q;
    bus.m_last_y    = 1'b0;

    case (state_q)
      LOAD: begin
        bus.s_ready_x   = 1'b1;
        // gated by reset so no write strobe escapes while held in reset
        bus.wr_en_x     = bus.s_valid_x & reset;
        bus.addr_x_base = wcnt_q;
        if (bus.s_valid_x) begin
          if (wcnt_q == ADDR_X'(X_COUNT - 1)) begin
            state_d = COMPUTE;
            wcnt_d  = '0;
            g_d     = '0;
            k_d     = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      COMPUTE: begin
        issue           = 1'b1;
        bus.addr_f      = k_q;
        bus.addr_x_base = g_q + ADDR_X'(k_q);
        if (k_q == ADDR_F'(F_COUNT - 1)) begin
          state_d = FLUSH;
          k_d     = '0;
          fcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      // Last tap is still in the read/multiply pipe; hold off the drain
      // until its accumulate has happened.
      FLUSH: begin
        if (fcnt_q == FW'(PIPE_LAT - 1)) begin
          state_d = DRAIN;
          lane_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end

      DRAIN: begin
        bus.m_valid_y = 1'b1;
        bus.m_last_y  = (int'(g_q) + int'(lane_q) == N_OUT - 1);
        if (bus.m_ready_y) begin
          if (int'(lane_q) == lanes - 1) begin
            // accumulators are free once the last lane has been taken
            bus.clear_acc = 1'b1;
            lane_d        = '0;
            if (int'(g_q) + P < N_OUT) begin
              state_d = COMPUTE;
              g_d     = g_q + ADDR_X'(P);
            end else begin
              state_d = LOAD;
              wcnt_d  = '0;
              g_d     = '0;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end

      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: randomized bench for conv_sched. A behavioural datapath
// (x memory, filter ROM, read/multiply pipe, P accumulators) follows the
// DUT's addresses and strobes; drained values are compared with a direct
// convolution of the loaded data. A second instance with a short last
// group covers the partial-drain case.
module tb_conv_sched;

  localparam int XA  = 64, FA = 33, PA = 8, PL = 2;
  localparam int OPA = XA - FA + 1;
  localparam int NGA = (OPA + PA - 1) / PA;
  localparam int XB  = 20, FB = 8, PB = 8;
  localparam int OPB = XB - FB + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_sched_if #(.ADDR_X($clog2(XA)), .ADDR_F($clog2(FA)), .LANE_W($clog2(PA))) ifa ();
  conv_sched_if #(.ADDR_X($clog2(XB)), .ADDR_F($clog2(FB)), .LANE_W($clog2(PB))) ifb ();

  conv_sched #(.X_COUNT(XA), .F_COUNT(FA), .P(PA), .PIPE_LAT(PL)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.master));
  conv_sched #(.X_COUNT(XB), .F_COUNT(FB), .P(PB), .PIPE_LAT(PL)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.master));

  int n_chk = 0, n_err = 0;
  int xv[XA];
  int fv[FA];
  int x_in;
  int a_nout;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint gold(input int n);
    longint s = 0;
    for (int k = 0; k < FA; k++) s += longint'(xv[n + k]) * fv[k];
    return s;
  endfunction

  // ---------------- behavioural datapath for instance A ----------------
  int     xm[XA];
  int     p1_ax, p1_af;
  longint prod[PA];
  longint acc[PA];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_ax <= 0;
      p1_af <= 0;
      for (int i = 0; i < PA; i++) begin
        prod[i] <= 0;
        acc[i]  <= 0;
      end
    end else begin
      if (ifa.wr_en_x) xm[ifa.addr_x_base] <= x_in;
      p1_ax <= int'(ifa.addr_x_base);
      p1_af <= int'(ifa.addr_f);
      for (int i = 0; i < PA; i++) begin
        prod[i] <= (p1_ax + i < XA) ? longint'(xm[p1_ax + i]) * fv[p1_af] : 0;
        if (ifa.clear_acc)   acc[i] <= 0;
        else if (ifa.en_acc) acc[i] <= acc[i] + prod[i];
      end
      // live lanes of the group being computed must stay inside x
      if (!ifa.s_ready_x && !ifa.m_valid_y) begin
        int lc;
        lc = (OPA - a_nout < PA) ? OPA - a_nout : PA;
        if (int'(ifa.addr_x_base) + lc - 1 > XA - 1)
          chk("addr_bound", int'(ifa.addr_x_base) + lc - 1, XA - 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_a(input bit tog);
    int i = 0, guard = 0;
    while (i < XA && guard < 2000) begin
      @(negedge clk);
      guard++;
      ifa.s_valid_x = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      x_in = xv[i];
      #1;
      if (ifa.s_valid_x) begin
        chk("load_ready", ifa.s_ready_x, 1);
        chk("load_addr", ifa.addr_x_base, i);
        chk("load_wr", ifa.wr_en_x, 1);
        i++;
      end else begin
        chk("load_wr_idle", ifa.wr_en_x, 0);
      end
    end
    if (i < XA) chk("load_timeout", i, XA);
  endtask

  // mode 0: m_ready held 1; 1: 5-cycle stall at group 1 lane 3; 2: random ready
  task automatic run_a(input int mode, input bit tog, input int rst_at);
    int cyc = 0, n = 0, run_len = 0, runs = 0, clears = 0, first_en = -1, stall = 0;
    longint ax_f = 0, af_f = 0;
    a_nout = 0;
    for (int i = 0; i < XA; i++) xv[i] = $urandom_range(0, 15);
    load_a(tog);
    while (n < OPA && cyc < 5000) begin
      @(negedge clk);
      ifa.s_valid_x = 1'($urandom_range(0, 1));
      x_in = $urandom_range(0, 15);
      if (mode == 1 && n == PA + 3 && stall < 5) ifa.m_ready_y = 1'b0;
      else if (mode == 2) ifa.m_ready_y = ($urandom_range(0, 3) != 0);
      else ifa.m_ready_y = 1'b1;
      if (rst_at >= 0 && n == rst_at) ifa.m_ready_y = 1'b0;
      #1;
      if (cyc == 0) begin
        chk("compute_ready", ifa.s_ready_x, 0);
        chk("first_addr_f", ifa.addr_f, 0);
        chk("first_addr_x", ifa.addr_x_base, 0);
      end
      if (ifa.s_valid_x && !ifa.s_ready_x) chk("wr_ignored", ifa.wr_en_x, 0);
      if (ifa.en_acc) begin
        if (first_en < 0) first_en = cyc;
        run_len++;
      end else if (run_len > 0) begin
        chk("en_len", run_len, FA);
        runs++;
        run_len = 0;
      end
      if (mode == 1 && n == PA + 3 && !ifa.m_ready_y) begin
        chk("bp_valid", ifa.m_valid_y, 1);
        if (stall == 0) begin
          ax_f = ifa.addr_x_base;
          af_f = ifa.addr_f;
        end else begin
          chk("bp_addr_x", ifa.addr_x_base, ax_f);
          chk("bp_addr_f", ifa.addr_f, af_f);
        end
        stall++;
      end
      if (ifa.m_valid_y) begin
        if (rst_at >= 0 && n == rst_at) begin
          ifa.s_valid_x = 1'b0;
          reset = 1'b0;
          #1;
          chk("rst_m_valid", ifa.m_valid_y, 0);
          chk("rst_lane", ifa.lane_sel, 0);
          chk("rst_en_acc", ifa.en_acc, 0);
          chk("rst_clear", ifa.clear_acc, 0);
          chk("rst_wr", ifa.wr_en_x, 0);
          chk("rst_ready", ifa.s_ready_x, 1);
          repeat (2) @(negedge clk);
          reset = 1'b1;
          #1;
          chk("rst_rel_ready", ifa.s_ready_x, 1);
          chk("rst_rel_addr", ifa.addr_x_base, 0);
          return;
        end
        chk("lane_sel", ifa.lane_sel, n % PA);
        if (ifa.m_ready_y) begin
          chk("y_value", acc[ifa.lane_sel], gold(n));
          chk("m_last", ifa.m_last_y, n == OPA - 1);
          chk("clear_acc", ifa.clear_acc, (n % PA == PA - 1) || (n == OPA - 1));
          if (ifa.clear_acc) clears++;
          if (mode == 0 && n % PA == PA - 1)
            chk("grp_period", cyc, (n / PA + 1) * (FA + PL + PA) - 1);
          n++;
          a_nout = n;
        end else begin
          chk("clear_stall", ifa.clear_acc, 0);
        end
      end
      cyc++;
    end
    if (n < OPA) begin
      chk("drain_timeout", n, OPA);
    end else begin
      @(negedge clk);
      ifa.s_valid_x = 1'b0;
      ifa.m_ready_y = 1'b0;
      #1;
      chk("reload_ready", ifa.s_ready_x, 1);
      chk("done_valid", ifa.m_valid_y, 0);
      chk("clear_count", clears, NGA);
      chk("en_runs", runs, NGA);
      chk("first_en", first_en, PL);
      if (mode == 1) chk("bp_stalls", stall, 5);
    end
  endtask

  task automatic run_b();
    int i = 0, n = 0, cyc = 0, run_len = 0, max1 = -1;
    while (i < XB && cyc < 500) begin
      @(negedge clk);
      ifb.s_valid_x = 1'b1;
      #1;
      chk("b_load_addr", ifb.addr_x_base, i);
      i++;
      cyc++;
    end
    while (n < OPB && cyc < 2000) begin
      @(negedge clk);
      ifb.s_valid_x = 1'($urandom_range(0, 1));
      ifb.m_ready_y = ($urandom_range(0, 2) != 0);
      #1;
      if (ifb.s_valid_x && !ifb.s_ready_x) chk("b_wr_ignored", ifb.wr_en_x, 0);
      if (ifb.en_acc) run_len++;
      else if (run_len > 0) begin
        chk("b_en_len", run_len, FB);
        run_len = 0;
      end
      if (ifb.m_valid_y) begin
        chk("b_lane_sel", ifb.lane_sel, n % PB);
        if (ifb.m_ready_y) begin
          chk("b_m_last", ifb.m_last_y, n == OPB - 1);
          chk("b_clear", ifb.clear_acc, (n == PB - 1) || (n == OPB - 1));
          if (n >= PB && int'(ifb.lane_sel) > max1) max1 = int'(ifb.lane_sel);
          n++;
        end
      end
      cyc++;
    end
    chk("b_outputs", n, OPB);
    chk("b_grp1_last_lane", max1, OPB - PB - 1);
    @(negedge clk);
    ifb.s_valid_x = 1'b0;
    ifb.m_ready_y = 1'b0;
    #1;
    chk("b_reload_ready", ifb.s_ready_x, 1);
    chk("b_done_valid", ifb.m_valid_y, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.s_valid_x = 1'b0;
    ifa.m_ready_y = 1'b0;
    ifb.s_valid_x = 1'b0;
    ifb.m_ready_y = 1'b0;
    x_in = 0;
    a_nout = 0;
    for (int i = 0; i < XA; i++) xm[i] = 0;
    for (int k = 0; k < FA; k++) fv[k] = $urandom_range(0, 15);
    #1;
    chk("reset_ready", ifa.s_ready_x, 1);
    chk("reset_valid", ifa.m_valid_y, 0);
    chk("reset_en_acc", ifa.en_acc, 0);
    chk("reset_clear", ifa.clear_acc, 0);
    chk("reset_addr_x", ifa.addr_x_base, 0);
    chk("reset_addr_f", ifa.addr_f, 0);
    chk("reset_lane", ifa.lane_sel, 0);
    chk("reset_last", ifa.m_last_y, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_a(0, 1'b0, -1);   // full-rate golden run
    run_a(1, 1'b1, -1);   // toggling load, stall at group 1 lane 3
    run_a(2, 1'b1, -1);   // random backpressure
    run_a(0, 1'b0, 2);    // reset while draining lane 2
    run_a(0, 1'b0, -1);   // clean run after the reset
    run_b();              // short last group

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
